// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared state encoding and character codes for the text screen buffer
package text_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL_COPY,
        SCROLL_FILL
    } state_t;

    localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

endpackage

// File: rtl/text_screen_buffer_if.sv
// rtl/text_screen_buffer_if.sv - CPU command, status and display read signals of the screen buffer
interface text_screen_buffer_if #(
    parameter int ADDR_W = 6,
    parameter int CHAR_W = 8
);

    logic              wrEn;
    logic [ADDR_W-1:0] wrIndex;
    logic [CHAR_W-1:0] wrChar;
    logic              putEn;
    logic [CHAR_W-1:0] putChar;
    logic              clearEn;
    logic              scrollEn;
    logic              busy;
    logic [ADDR_W-1:0] cursorIndex;
    logic [ADDR_W-1:0] rdIndex;
    logic [CHAR_W-1:0] rdChar;

    modport master (
        output wrEn, wrIndex, wrChar, putEn, putChar, clearEn, scrollEn, rdIndex,
        input  busy, cursorIndex, rdChar
    );

    modport slave (
        input  wrEn, wrIndex, wrChar, putEn, putChar, clearEn, scrollEn, rdIndex,
        output busy, cursorIndex, rdChar
    );

endinterface

// File: rtl/text_screen_buffer.sv
// rtl/text_screen_buffer.sv - character store with cursor put, clear and scroll-up sequencers
module text_screen_buffer
    import text_pkg::*;
#(
    parameter int              COLS      = 16,
    parameter int              ROWS      = 4,
    parameter int              CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(CHAR_SPACE)
) (
    input  logic               clk,
    input  logic               reset,
    text_screen_buffer_if.slave bus
);

    localparam int N      = ROWS * COLS;
    localparam int ADDR_W = $clog2(N);
    localparam int SEQ_W  = ADDR_W + 1;

    localparam logic [SEQ_W-1:0]  N_S           = SEQ_W'(N);
    localparam logic [SEQ_W-1:0]  COLS_S        = SEQ_W'(COLS);
    localparam logic [SEQ_W-1:0]  LAST_S        = SEQ_W'(N - 1);
    localparam logic [SEQ_W-1:0]  COPY_END_S    = SEQ_W'(N - COLS - 1);
    localparam logic [SEQ_W-1:0]  ONE_S         = SEQ_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);

    state_t            state;
    logic [SEQ_W-1:0]  seq_idx;
    logic [ADDR_W-1:0] cursor;
    logic [CHAR_W-1:0] rd_char;
    logic [CHAR_W-1:0] mem [N];

    logic [SEQ_W-1:0]  cursor_ext;
    logic [SEQ_W-1:0]  next_row_base;
    logic [SEQ_W-1:0]  copy_src;
    logic              idle;
    logic              put_newline;
    logic              put_scrolls;
    logic              wr_index_ok;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CHAR_W-1:0] wdata;

    assign idle          = (state == IDLE);
    assign cursor_ext    = {1'b0, cursor};
    assign next_row_base = (cursor_ext / COLS_S + ONE_S) * COLS_S;
    assign copy_src      = seq_idx + COLS_S;
    assign put_newline   = (bus.putChar == CHAR_W'(CHAR_NEWLINE));
    assign put_scrolls   = put_newline ? (cursor >= LAST_ROW_BASE) : (cursor == LAST_CELL);
    assign wr_index_ok   = ({1'b0, bus.wrIndex} < N_S);

    assign bus.busy        = !idle;
    assign bus.cursorIndex = cursor;
    assign bus.rdChar      = rd_char;

    // Single write port shared by CPU commands (only in IDLE) and the sequencers.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state)
            IDLE: begin
                if (!bus.clearEn && !bus.scrollEn) begin
                    if (bus.putEn) begin
                        if (!put_newline) begin
                            we    = 1'b1;
                            waddr = cursor;
                            wdata = bus.putChar;
                        end
                    end else if (bus.wrEn && wr_index_ok) begin
                        we    = 1'b1;
                        waddr = bus.wrIndex;
                        wdata = bus.wrChar;
                    end
                end
            end
            CLEAR, SCROLL_FILL: begin
                we    = 1'b1;
                waddr = seq_idx[ADDR_W-1:0];
                wdata = FILL_CHAR;
            end
            SCROLL_COPY: begin
                we    = 1'b1;
                waddr = seq_idx[ADDR_W-1:0];
                wdata = mem[copy_src[ADDR_W-1:0]];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= wdata;
        end
    end

    // Display read sees the pre-write value of a cell written in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_char <= '0;
        end else begin
            rd_char <= mem[bus.rdIndex];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            seq_idx <= '0;
            cursor  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clearEn) begin
                        state   <= CLEAR;
                        seq_idx <= '0;
                        cursor  <= '0;
                    end else if (bus.scrollEn) begin
                        state   <= SCROLL_COPY;
                        seq_idx <= '0;
                    end else if (bus.putEn) begin
                        if (put_scrolls) begin
                            cursor  <= LAST_ROW_BASE;
                            state   <= SCROLL_COPY;
                            seq_idx <= '0;
                        end else if (put_newline) begin
                            cursor <= next_row_base[ADDR_W-1:0];
                        end else begin
                            cursor <= cursor + ONE_A;
                        end
                    end
                end
                CLEAR, SCROLL_FILL: begin
                    if (seq_idx == LAST_S) begin
                        state   <= IDLE;
                        seq_idx <= '0;
                    end else begin
                        seq_idx <= seq_idx + ONE_S;
                    end
                end
                SCROLL_COPY: begin
                    seq_idx <= seq_idx + ONE_S;
                    if (seq_idx == COPY_END_S) begin
                        state <= SCROLL_FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_screen_buffer.sv
// tb/tb_text_screen_buffer.sv - randomized and directed self-checking bench for text_screen_buffer
module tb_text_screen_buffer;
    import text_pkg::*;

    localparam int COLS = 16;
    localparam int ROWS = 4;
    localparam int N    = COLS * ROWS;
    localparam int AW   = 6;
    localparam int CW   = 8;
    localparam logic [7:0] FILL = 8'h20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_screen_buffer_if #(.ADDR_W(AW), .CHAR_W(CW)) bus ();

    text_screen_buffer #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .FILL_CHAR(FILL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: whole-command effects applied at acceptance time.
    logic [7:0] m_mem [N];
    int         m_cursor;
    int         m_busy_left;
    logic [7:0] m_rd;
    bit         m_rd_valid = 1'b0;
    bit         m_live     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_fill_all();
        for (int i = 0; i < N; i++) m_mem[i] = FILL;
    endtask

    task automatic m_scroll();
        for (int i = 0; i < N - COLS; i++) m_mem[i] = m_mem[i + COLS];
        for (int i = N - COLS; i < N; i++) m_mem[i] = FILL;
        m_busy_left = N;
    endtask

    task automatic m_step();
        if (reset) begin
            m_fill_all();
            m_cursor    = 0;
            m_busy_left = N;
            m_rd        = 8'h00;
            m_rd_valid  = 1'b1;
            m_live      = 1'b1;
            return;
        end
        if (!m_live) return;
        m_rd_valid = (m_busy_left == 0);
        m_rd       = m_mem[bus.rdIndex];
        if (m_busy_left > 0) begin
            m_busy_left--;
            return;
        end
        if (bus.clearEn) begin
            m_fill_all();
            m_cursor    = 0;
            m_busy_left = N;
        end else if (bus.scrollEn) begin
            m_scroll();
        end else if (bus.putEn) begin
            if (bus.putChar == 8'h0A) begin
                if (m_cursor / COLS == ROWS - 1) begin
                    m_cursor = (ROWS - 1) * COLS;
                    m_scroll();
                end else begin
                    m_cursor = (m_cursor / COLS + 1) * COLS;
                end
            end else begin
                m_mem[m_cursor] = bus.putChar;
                if (m_cursor == N - 1) begin
                    m_cursor = (ROWS - 1) * COLS;
                    m_scroll();
                end else begin
                    m_cursor++;
                end
            end
        end else if (bus.wrEn) begin
            m_mem[bus.wrIndex] = bus.wrChar;
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("busy", 32'(bus.busy), 32'(m_busy_left > 0));
            chk("cursor", 32'(bus.cursorIndex), 32'(m_cursor));
            if (m_rd_valid) chk("rdchar", 32'(bus.rdChar), 32'(m_rd));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic strobes_off();
        bus.wrEn = 1'b0; bus.putEn = 1'b0; bus.clearEn = 1'b0; bus.scrollEn = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            cnt++;
            cyc();
        end
    endtask

    task automatic read_cell(input string name, input int idx, input logic [7:0] exp);
        bus.rdIndex = AW'(idx);
        cyc();
        chk(name, 32'(bus.rdChar), 32'(exp));
    endtask

    task automatic put(input logic [7:0] c);
        bus.putEn = 1'b1; bus.putChar = c;
        cyc();
        bus.putEn = 1'b0;
    endtask

    task automatic check_all_fill(input string name);
        for (int i = 0; i < N; i++) read_cell(name, i, FILL);
    endtask

    int cnt;

    initial begin
        strobes_off();
        bus.wrIndex = '0; bus.wrChar = '0; bus.putChar = '0; bus.rdIndex = '0;
        reset = 1'b1;
        cyc(); cyc();

        reset = 1'b0;
        count_busy(cnt);
        chk("reset_busy_cycles", 32'(cnt), 32'd64);
        chk("reset_cursor", 32'(bus.cursorIndex), 32'd0);
        check_all_fill("reset_cells");

        bus.rdIndex = 6'd5;
        bus.wrEn = 1'b1; bus.wrIndex = 6'd5; bus.wrChar = 8'h41;
        cyc();
        chk("wr_read_old", 32'(bus.rdChar), 32'h20);
        bus.wrEn = 1'b0;
        cyc();
        chk("wr_read_new", 32'(bus.rdChar), 32'h41);
        chk("wr_cursor", 32'(bus.cursorIndex), 32'd0);

        put(8'h48); put(8'h49); put(8'h0A); put(8'h58);
        chk("put_cursor", 32'(bus.cursorIndex), 32'd17);
        read_cell("put_cell0", 0, 8'h48);
        read_cell("put_cell1", 1, 8'h49);
        read_cell("put_cell16", 16, 8'h58);

        bus.clearEn = 1'b1; cyc(); bus.clearEn = 1'b0;
        count_busy(cnt);
        chk("clear_busy_cycles", 32'(cnt), 32'd64);
        for (int i = 0; i < N; i++) put(8'(8'h61 + i));
        count_busy(cnt);
        chk("fill_scroll_busy", 32'(cnt), 32'd64);
        chk("fill_cursor", 32'(bus.cursorIndex), 32'd48);
        for (int i = 0; i < N; i++)
            read_cell("fill_cells", i, (i < N - COLS) ? 8'(8'h61 + 16 + i) : FILL);

        bus.clearEn = 1'b1; bus.wrEn = 1'b1; bus.wrIndex = 6'd7; bus.wrChar = 8'h5A;
        cyc();
        bus.clearEn = 1'b0;
        count_busy(cnt);
        bus.wrEn = 1'b0;
        chk("clear_hold_wr_busy", 32'(cnt), 32'd64);
        check_all_fill("clear_hold_wr_cells");

        put(8'h51);
        bus.clearEn = 1'b1; bus.putEn = 1'b1; bus.putChar = 8'h52;
        cyc();
        strobes_off();
        chk("clear_wins_cursor", 32'(bus.cursorIndex), 32'd0);
        chk("clear_wins_busy", 32'(bus.busy), 32'd1);
        count_busy(cnt);
        read_cell("clear_wins_cell0", 0, FILL);
        read_cell("clear_wins_cell1", 1, FILL);

        put(8'h31); put(8'h32);
        bus.scrollEn = 1'b1; cyc(); bus.scrollEn = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0;
        count_busy(cnt);
        chk("abort_busy_cycles", 32'(cnt), 32'd64);
        chk("abort_cursor", 32'(bus.cursorIndex), 32'd0);
        check_all_fill("abort_cells");

        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 999));
            reset        = (r < 2);
            bus.clearEn  = (r >= 2 && r < 6);
            bus.scrollEn = (r >= 6 && r < 12);
            bus.putEn    = ($urandom_range(0, 2) == 0);
            bus.putChar  = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(8'h21, 8'h7E));
            bus.wrEn     = ($urandom_range(0, 1) == 0);
            bus.wrIndex  = AW'($urandom_range(0, N - 1));
            bus.wrChar   = 8'($urandom);
            bus.rdIndex  = AW'($urandom_range(0, N - 1));
            cyc();
        end
        reset = 1'b0;
        strobes_off();
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
